pixel_scan_generator: RTL and testbench
=======================================

PIXEL_SCAN_GENERATOR -- requirements
Module: pixel_scan_generator

Interface
REQ-001 Parameter COORD_W, default 16, SHALL set the unsigned pixel-coordinate width.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 resetn  in  1  SHALL be the reset: synchronous, active-low.
REQ-004 tri_valid, tri_ready  in/out  1  SHALL form the triangle-input handshake.
REQ-005 xmin, xmax, ymin, ymax  in  COORD_W  SHALL give the inclusive integer bounding box.
REQ-006 Pa_in, Pb_in, Pc_in  in  66  SHALL give the vertices as recFN(8,24) pairs {x[65:33], y[32:0]}.
REQ-007 pt_valid, pt_ready  out/in  1  SHALL form the sample-point handshake toward the point sampler.
REQ-008 Pin  out  66  SHALL give the pixel centre {x+0.5, y+0.5} as recFN(8,24).
REQ-009 px_x, px_y  out  COORD_W  SHALL give the integer pixel coordinates of the current point.
REQ-010 Pa, Pb, Pc  out  66  SHALL give the registered vertices of the triangle being scanned.
REQ-011 pt_last  out  1  SHALL mark the final point of a triangle.
REQ-012 empty_drop  out  1  SHALL pulse for one cycle when a triangle with an empty box is discarded.

Function
REQ-013 FSM states SHALL be IDLE and SCAN only.
REQ-014 tri_ready SHALL be 1 exactly when the state is IDLE and resetn is 1.
REQ-015 On tri_valid&&tri_ready with xmin<=xmax and ymin<=ymax, the block SHALL register the box and vertices, load x=xmin and y=ymin, and enter SCAN.
REQ-016 pt_valid SHALL be 1 exactly when the state is SCAN; the first point is valid the cycle after acceptance (latency 1).
REQ-017 On tri_valid&&tri_ready with xmin>xmax or ymin>ymax, the block SHALL stay in IDLE and pulse empty_drop the next cycle; no point is emitted.
REQ-018 Scan order SHALL be row-major: x increments from xmin to xmax, then x returns to xmin and y increments.
REQ-019 The block SHALL advance only on pt_valid&&pt_ready; while pt_ready=0, Pin, px_x, px_y, Pa/Pb/Pc and pt_last SHALL hold.
REQ-020 pt_last SHALL equal (x==xmax)&&(y==ymax) while in SCAN, and 0 otherwise.
REQ-021 A handshake with pt_last=1 SHALL return the FSM to IDLE; tri_ready rises the next cycle (there is no same-cycle re-accept).
REQ-022 End-of-row and end-of-box SHALL be detected by equality before incrementing, so xmax or ymax = 2^COORD_W-1 never wraps or overflows.
REQ-023 Pin SHALL be exact: each coordinate equals (2c+1) on COORD_W+1 bits, converted to recFN with the recoded exponent decremented by 1 (the value is never zero, so no special case).
REQ-024 Pin SHALL be combinational from the registered x and y; no extra cycle of latency.
REQ-025 Pa/Pb/Pc SHALL be constant for all points of one triangle.

Reset
REQ-026 While resetn=0 at a clock edge: state=IDLE, pt_valid=0, pt_last=0, empty_drop=0, tri_ready=0, and x, y, px_x, px_y, box registers, Pa, Pb, Pc all = 0.
REQ-027 Reset asserted mid-SCAN SHALL abandon the triangle; no further point of it is emitted after reset.

Structure
REQ-028 The shared package SHALL hold REC_EXP_W=8, REC_SIG_W=24, REC_W=33, POINT_W=66, and the FSM state enum.
REQ-029 Sub-module pixel_centre_to_rec SHALL wrap the HardFloat integer-to-recFN converter (unsigned, rounding mode irrelevant) and apply the exponent decrement; it is instantiated once for x and once for y.

Verification
REQ-030 Box (3,3,5,5) with pt_ready=1 -> exactly one point: Pin={3.5,5.5} in recFN, pt_last=1, tri_ready=1 two cycles after acceptance.
REQ-031 Box x 0..1, y 0..1 -> point order (0,0),(1,0),(0,1),(1,1) on consecutive cycles, with pt_last only on (1,1).
REQ-032 Box x 2..4, y 7..7 with pt_ready toggling 1,0,0,1,1 -> three points, each held stable while stalled, and no duplicate or skipped point.
REQ-033 Box xmin=5, xmax=4 -> empty_drop pulses once, pt_valid stays 0, and the next triangle is accepted normally.
REQ-034 Box x 65534..65535, y 65535..65535 -> two points, Pin x = 65534.5 then 65535.5, and the FSM returns to IDLE with no wrap to 0.
REQ-035 resetn=0 for 1 cycle after the 2nd point of a 3x3 box -> pt_valid=0 from the next edge, tri_ready=1 after release, and the new triangle starts at its own xmin, ymin.

Source files
------------

// File: rtl/pixel_scan_generator_pkg.sv
// Shared constants and state type for the pixel scan generator.
package pixel_scan_generator_pkg;

   localparam int REC_EXP_W = 8;
   localparam int REC_SIG_W = 24;
   localparam int REC_W     = 33;
   localparam int POINT_W   = 66;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_state_t;

endpackage

// File: rtl/pixel_scan_generator_centre.sv
// Integer-to-recFN(8,24) conversion of a pixel centre c+0.5.
// The integer 2c+1 is converted exactly (it always fits the 24-bit
// significand), then the recoded exponent is lowered by one to halve it.
// The input is never zero, so the zero/special encodings are not needed.
module pixel_centre_to_rec
   import pixel_scan_generator_pkg::*;
#(
   parameter int COORD_W = 16
) (
   input  logic [COORD_W-1:0] coord,
   output logic [REC_W-1:0]   rec
);

   localparam int VAL_W  = COORD_W + 1;
   localparam int FRAC_W = REC_SIG_W - 1;
   localparam int POS_W  = $clog2(REC_SIG_W);
   // Recoded exponent of 2^p is 2^REC_EXP_W + p; the halving makes it 2^REC_EXP_W - 1 + p.
   localparam logic [REC_EXP_W:0] EXP_BASE = (REC_EXP_W+1)'((1 << REC_EXP_W) - 1);

   logic [VAL_W-1:0]     val;
   logic [POS_W-1:0]     lead;
   logic [REC_SIG_W-1:0] norm;
   logic [REC_EXP_W:0]   exp_rec;

   assign val = {coord, 1'b1};

   // Leading-one position of the odd integer 2c+1.
   always_comb begin
      lead = '0;
      for (int i = 0; i < VAL_W; i++) begin
         if (val[i]) lead = POS_W'(i);
      end
   end

   // Normalise so the leading one sits at the hidden-bit position.
   always_comb begin
      norm    = REC_SIG_W'(val) << (POS_W'(FRAC_W) - lead);
      exp_rec = EXP_BASE + (REC_EXP_W+1)'(lead);
   end

   assign rec = {1'b0, exp_rec, norm[FRAC_W-1:0]};

endmodule

// File: rtl/pixel_scan_generator.sv
// Walks a triangle's inclusive bounding box in row-major order and emits
// one sample point per handshake, with the pixel centre in recFN form.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a triangle; tri_ready high (out of reset)
// SCAN  | emitting points of the registered box; pt_valid high
module pixel_scan_generator
   import pixel_scan_generator_pkg::*;
#(
   parameter int COORD_W = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 tri_valid,
   output logic                 tri_ready,
   input  logic [COORD_W-1:0]   xmin,
   input  logic [COORD_W-1:0]   xmax,
   input  logic [COORD_W-1:0]   ymin,
   input  logic [COORD_W-1:0]   ymax,
   input  logic [POINT_W-1:0]   Pa_in,
   input  logic [POINT_W-1:0]   Pb_in,
   input  logic [POINT_W-1:0]   Pc_in,
   output logic                 pt_valid,
   input  logic                 pt_ready,
   output logic [POINT_W-1:0]   Pin,
   output logic [COORD_W-1:0]   px_x,
   output logic [COORD_W-1:0]   px_y,
   output logic [POINT_W-1:0]   Pa,
   output logic [POINT_W-1:0]   Pb,
   output logic [POINT_W-1:0]   Pc,
   output logic                 pt_last,
   output logic                 empty_drop
);

   scan_state_t         state, state_nxt;
   logic [COORD_W-1:0]  x, y;
   logic [COORD_W-1:0]  xmin_r, xmax_r, ymax_r;
   logic                accept, box_ok, advance;
   logic [REC_W-1:0]    x_rec, y_rec;

   assign tri_ready = (state == IDLE) && resetn;
   assign pt_valid  = (state == SCAN);
   // Equality compare before increment keeps a box edge at all-ones from wrapping.
   assign pt_last   = (state == SCAN) && (x == xmax_r) && (y == ymax_r);
   assign accept    = tri_valid && tri_ready;
   assign box_ok    = (xmin <= xmax) && (ymin <= ymax);
   assign advance   = pt_valid && pt_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state: enter SCAN on a non-empty box, leave on the last handshake.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && box_ok) state_nxt = SCAN;
         SCAN:    if (advance && pt_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Box/vertex capture, row-major coordinate stepping and empty-box pulse.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         x          <= '0;
         y          <= '0;
         xmin_r     <= '0;
         xmax_r     <= '0;
         ymax_r     <= '0;
         Pa         <= '0;
         Pb         <= '0;
         Pc         <= '0;
         empty_drop <= 1'b0;
      end else begin
         empty_drop <= 1'b0;
         if (accept) begin
            if (box_ok) begin
               x      <= xmin;
               y      <= ymin;
               xmin_r <= xmin;
               xmax_r <= xmax;
               ymax_r <= ymax;
               Pa     <= Pa_in;
               Pb     <= Pb_in;
               Pc     <= Pc_in;
            end else begin
               empty_drop <= 1'b1;
            end
         end else if (advance) begin
            if (x == xmax_r) begin
               x <= xmin_r;
               if (y != ymax_r) y <= y + 1'b1;
            end else begin
               x <= x + 1'b1;
            end
         end
      end
   end

   assign px_x = x;
   assign px_y = y;

   pixel_centre_to_rec #(.COORD_W(COORD_W)) u_centre_x (.coord(x), .rec(x_rec));
   pixel_centre_to_rec #(.COORD_W(COORD_W)) u_centre_y (.coord(y), .rec(y_rec));

   assign Pin = {x_rec, y_rec};

endmodule

// File: tb/tb_pixel_scan_generator.sv
// Directed bench for pixel_scan_generator; recFN constants are hand-derived.
module tb_pixel_scan_generator;

   logic        clk = 1'b0;
   logic        resetn;
   logic        tri_valid;
   logic        tri_ready;
   logic [15:0] xmin, xmax, ymin, ymax;
   logic [65:0] Pa_in, Pb_in, Pc_in;
   logic        pt_valid;
   logic        pt_ready;
   logic [65:0] Pin;
   logic [15:0] px_x, px_y;
   logic [65:0] Pa, Pb, Pc;
   logic        pt_last;
   logic        empty_drop;

   int checks   = 0;
   int failures = 0;

   // recFN(8,24) encodings of c+0.5
   localparam logic [32:0] R0_5     = 33'h0_7F80_0000;
   localparam logic [32:0] R1_5     = 33'h0_8040_0000;
   localparam logic [32:0] R2_5     = 33'h0_80A0_0000;
   localparam logic [32:0] R3_5     = 33'h0_80E0_0000;
   localparam logic [32:0] R4_5     = 33'h0_8110_0000;
   localparam logic [32:0] R5_5     = 33'h0_8130_0000;
   localparam logic [32:0] R6_5     = 33'h0_8150_0000;
   localparam logic [32:0] R7_5     = 33'h0_8170_0000;
   localparam logic [32:0] R65534_5 = 33'h0_87FF_FE80;
   localparam logic [32:0] R65535_5 = 33'h0_87FF_FF80;

   localparam logic [65:0] VA = 66'h1_2345_6789_ABCD_EF01;
   localparam logic [65:0] VB = 66'h2_FEDC_BA98_7654_3210;
   localparam logic [65:0] VC = 66'h0_0F0F_F0F0_5A5A_A5A5;

   always #5 clk = ~clk;

   pixel_scan_generator #(.COORD_W(16)) dut (
      .clk(clk), .resetn(resetn),
      .tri_valid(tri_valid), .tri_ready(tri_ready),
      .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax),
      .Pa_in(Pa_in), .Pb_in(Pb_in), .Pc_in(Pc_in),
      .pt_valid(pt_valid), .pt_ready(pt_ready),
      .Pin(Pin), .px_x(px_x), .px_y(px_y),
      .Pa(Pa), .Pb(Pb), .Pc(Pc),
      .pt_last(pt_last), .empty_drop(empty_drop)
   );

   task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_tri(input logic [15:0] x0, input logic [15:0] x1,
                           input logic [15:0] y0, input logic [15:0] y1);
      check("tri_ready_before_send", tri_ready, 1);
      xmin = x0; xmax = x1; ymin = y0; ymax = y1;
      tri_valid = 1'b1;
      tick();
      tri_valid = 1'b0;
   endtask

   logic [15:0] sq_x [4];
   logic [15:0] sq_y [4];
   logic [65:0] sq_pin [4];
   logic        st_rdy [5];
   logic [15:0] st_x [5];
   logic        st_last [5];
   logic [65:0] st_pin [5];

   initial begin
      resetn = 1'b0; tri_valid = 1'b0; pt_ready = 1'b0;
      xmin = '0; xmax = '0; ymin = '0; ymax = '0;
      Pa_in = VA; Pb_in = VB; Pc_in = VC;

      sq_x = '{16'd0, 16'd1, 16'd0, 16'd1};
      sq_y = '{16'd0, 16'd0, 16'd1, 16'd1};
      sq_pin = '{{R0_5, R0_5}, {R1_5, R0_5}, {R0_5, R1_5}, {R1_5, R1_5}};
      st_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      st_x    = '{16'd2, 16'd3, 16'd3, 16'd3, 16'd4};
      st_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      st_pin  = '{{R2_5, R7_5}, {R3_5, R7_5}, {R3_5, R7_5}, {R3_5, R7_5}, {R4_5, R7_5}};

      // Reset state
      tick(); tick();
      check("rst_tri_ready", tri_ready, 0);
      check("rst_pt_valid", pt_valid, 0);
      check("rst_pt_last", pt_last, 0);
      check("rst_empty_drop", empty_drop, 0);
      check("rst_px", {px_x, px_y}, 0);
      check("rst_Pa", Pa, 0);
      resetn = 1'b1;
      #1;
      check("idle_tri_ready", tri_ready, 1);

      // Single-pixel box
      pt_ready = 1'b1;
      send_tri(16'd3, 16'd3, 16'd5, 16'd5);
      check("one_pt_valid", pt_valid, 1);
      check("one_px", {px_x, px_y}, {16'd3, 16'd5});
      check("one_Pin", Pin, {R3_5, R5_5});
      check("one_last", pt_last, 1);
      check("one_tri_ready", tri_ready, 0);
      check("one_PaPbPc", {Pa ^ VA, Pb ^ VB, Pc ^ VC}, 0);
      tick();
      check("one_done_valid", pt_valid, 0);
      check("one_done_tri_ready", tri_ready, 1);

      // 2x2 row-major order
      Pa_in = VB; Pb_in = VC; Pc_in = VA;
      send_tri(16'd0, 16'd1, 16'd0, 16'd1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("sq_valid%0d", i), pt_valid, 1);
         check($sformatf("sq_px%0d", i), {px_x, px_y}, {sq_x[i], sq_y[i]});
         check($sformatf("sq_Pin%0d", i), Pin, sq_pin[i]);
         check($sformatf("sq_last%0d", i), pt_last, (i == 3) ? 1 : 0);
         check($sformatf("sq_Pa%0d", i), {Pa, Pc}, {VB, VA});
         tick();
      end
      check("sq_done_valid", pt_valid, 0);
      check("sq_done_last", pt_last, 0);

      // Stalled row 2..4 at y=7
      send_tri(16'd2, 16'd4, 16'd7, 16'd7);
      for (int i = 0; i < 5; i++) begin
         pt_ready = st_rdy[i];
         check($sformatf("stall_valid%0d", i), pt_valid, 1);
         check($sformatf("stall_px%0d", i), {px_x, px_y}, {st_x[i], 16'd7});
         check($sformatf("stall_Pin%0d", i), Pin, st_pin[i]);
         check($sformatf("stall_last%0d", i), pt_last, st_last[i]);
         check($sformatf("stall_Pb%0d", i), Pb, VC);
         tick();
      end
      check("stall_done_valid", pt_valid, 0);
      check("stall_done_tri_ready", tri_ready, 1);

      // Empty box discarded, then a normal triangle
      pt_ready = 1'b1;
      send_tri(16'd5, 16'd4, 16'd0, 16'd0);
      check("empty_pulse", empty_drop, 1);
      check("empty_valid", pt_valid, 0);
      check("empty_tri_ready", tri_ready, 1);
      tick();
      check("empty_pulse_end", empty_drop, 0);
      check("empty_valid2", pt_valid, 0);
      send_tri(16'd1, 16'd1, 16'd2, 16'd2);
      check("after_empty_valid", pt_valid, 1);
      check("after_empty_px", {px_x, px_y}, {16'd1, 16'd2});
      check("after_empty_last", pt_last, 1);
      check("after_empty_drop", empty_drop, 0);
      tick();

      // Top-of-range box, no wrap
      send_tri(16'd65534, 16'd65535, 16'd65535, 16'd65535);
      check("max0_px", {px_x, px_y}, {16'd65534, 16'd65535});
      check("max0_Pin", Pin, {R65534_5, R65535_5});
      check("max0_last", pt_last, 0);
      tick();
      check("max1_px", {px_x, px_y}, {16'd65535, 16'd65535});
      check("max1_Pin", Pin, {R65535_5, R65535_5});
      check("max1_last", pt_last, 1);
      tick();
      check("max_done_valid", pt_valid, 0);
      check("max_done_tri_ready", tri_ready, 1);
      tick();
      check("max_no_wrap_valid", pt_valid, 0);

      // Reset mid-scan
      send_tri(16'd1, 16'd3, 16'd1, 16'd3);
      check("rs_px0", {px_x, px_y}, {16'd1, 16'd1});
      tick();
      check("rs_px1", {px_x, px_y}, {16'd2, 16'd1});
      resetn = 1'b0;
      tick();
      check("rs_valid", pt_valid, 0);
      check("rs_tri_ready_low", tri_ready, 0);
      check("rs_px_cleared", {px_x, px_y}, 0);
      resetn = 1'b1;
      #1;
      check("rs_tri_ready_high", tri_ready, 1);
      tick();
      check("rs_still_idle", pt_valid, 0);
      send_tri(16'd4, 16'd5, 16'd6, 16'd6);
      check("rs_new_px0", {px_x, px_y}, {16'd4, 16'd6});
      check("rs_new_Pin0", Pin, {R4_5, R6_5});
      check("rs_new_last0", pt_last, 0);
      tick();
      check("rs_new_px1", {px_x, px_y}, {16'd5, 16'd6});
      check("rs_new_Pin1", Pin, {R5_5, R6_5});
      check("rs_new_last1", pt_last, 1);
      tick();
      check("rs_new_done", pt_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
